// File: rtl/seq_det_ctrl_if.sv
// Bundle of config, control, serial-input and status signals for seq_det_ctrl.
// The master drives config/control/stream; the slave (the detector) drives status.
interface seq_det_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    // x is consumed on every clk edge where x_vld is high; there is no back-pressure,
    // and cfg_we/start/abort are single-cycle strobes sampled on the same edge.
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic             cfg_ovl;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_rej;
    logic             start;
    logic             abort;
    logic             x;
    logic             x_vld;
    logic             z;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] match_cnt;
    logic [1:0]       dbg_state;

    modport master (
        output cfg_we, cfg_pat, cfg_ovl, cfg_target, start, abort, x, x_vld,
        input  cfg_rej, z, busy, done, timeout, match_cnt, dbg_state
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_ovl, cfg_target, start, abort, x, x_vld,
        output cfg_rej, z, busy, done, timeout, match_cnt, dbg_state
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector with IDLE/RUN/DONE sequencing and match counting.
// Optional RUN watchdog enabled by defining SEQDET_TIMEOUT_EN.
module seq_det_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_det_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int               FW       = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
    localparam logic [PAT_W-1:0] PAT_RST  = PAT_W'(4'b1010);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;
    logic             rej_q, rej_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SEQDET_TIMEOUT_EN
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             tmo_q, tmo_d;
`endif

    logic [PAT_W-1:0] win;
    logic [FW-1:0]    fill_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;
    logic             last;

    always_comb begin
        win      = {hist_q[PAT_W-2:0], bus.x};
        fill_inc = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FW'(1);
        cnt_inc  = cnt_q + CNT_W'(1);
        // A window only counts once PAT_W valid bits have been seen since start/last match.
        hit      = (state_q == S_RUN) && bus.x_vld && (fill_inc == FILL_MAX) && (win == pat_q);
        last     = (target_q != '0) && (cnt_inc == target_q);
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        target_d = target_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        z_d      = 1'b0;
        rej_d    = 1'b0;
`ifdef SEQDET_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        tmo_d    = tmo_q;
`endif
        if (bus.abort) begin
            state_d = S_IDLE;
`ifdef SEQDET_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
        end else if (bus.start && state_q != S_RUN) begin
            state_d = S_RUN;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
`ifdef SEQDET_TIMEOUT_EN
            to_cnt_d = '0;
            tmo_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    rej_d = bus.cfg_we;
                    if (bus.x_vld) begin
                        hist_d = win;
                        fill_d = fill_inc;
                    end
                    if (hit) begin
                        z_d   = 1'b1;
                        cnt_d = cnt_inc;
                        if (!ovl_q) fill_d = '0;
                        if (last) state_d = S_DONE;
                    end
`ifdef SEQDET_TIMEOUT_EN
                    // A match on the expiry edge takes precedence over the timeout.
                    if (hit) begin
                        to_cnt_d = '0;
                    end else if (to_cnt_q == '1) begin
                        state_d = S_DONE;
                        tmo_d   = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
`endif
                end
                default: begin
                    if (bus.cfg_we) begin
                        pat_d    = bus.cfg_pat;
                        ovl_d    = bus.cfg_ovl;
                        target_d = bus.cfg_target;
                    end
                end
            endcase
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pat_q    <= PAT_RST;
            ovl_q    <= 1'b0;
            target_q <= CNT_W'(1);
            hist_q   <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            z_q      <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQDET_TIMEOUT_EN
            to_cnt_q <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            ovl_q    <= ovl_d;
            target_q <= target_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            rej_q    <= rej_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SEQDET_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign bus.z         = z_q;
    assign bus.cfg_rej   = rej_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.match_cnt = cnt_q;
    assign bus.dbg_state = state_q;
`ifdef SEQDET_TIMEOUT_EN
    assign bus.timeout   = tmo_q;
`else
    assign bus.timeout   = 1'b0;
`endif
endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial sequence-detector controller. It holds a configurable PAT_W-bit target pattern and an overlap/non-overlap mode, and arms detection on command. It detects the pattern on a qualified serial bit stream, counts matches, and stops when a programmed match target is reached. It sits between a register/config master and the serial input path, replacing fixed hard-coded detector FSMs with one sequenced, reconfigurable resource.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- CNT_W, 8, match counter / target width
- TO_W, 12, timeout counter width (used only with SEQDET_TIMEOUT_EN)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- cfg_we  input  1  config write strobe, accepted only in IDLE
- cfg_pat  input  PAT_W  target pattern, MSB = first bit received
- cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_target  input  CNT_W  matches before DONE; 0 = run until abort
- cfg_rej  output  1  1-cycle pulse: cfg_we seen outside IDLE, write dropped
- start  input  1  arm detection (IDLE or DONE)
- abort  input  1  return to IDLE from any state
- x  input  1  serial data bit
- x_vld  input  1  x qualifier; bit consumed only when high
- z  output  1  registered 1-cycle match pulse
- busy  output  1  high in RUN
- done  output  1  high in DONE
- timeout  output  1  high in DONE if exit was by timeout (constant 0 without macro)
- match_cnt  output  CNT_W  matches since last start

## Operation
- Config regs reset to pat = 4'b1010 pattern (low PAT_W bits of 'b1010 zero-extended), ovl = 0, target = 1.
- FSM states: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: cfg_we latches cfg_pat/cfg_ovl/cfg_target. start -> RUN; clears history, fill count, match_cnt, timeout.
- RUN: on x_vld, win = {hist[PAT_W-2:0], x}; fill saturates at PAT_W. Match when fill + 1 >= PAT_W and win == pat.
- Match: z = 1 next cycle; match_cnt increments (wraps at 2^CNT_W if target = 0).
  - Non-overlap mode: fill clears to 0 (history discarded).
  - Overlap mode: history retained.
- Match with match_cnt + 1 == target (target != 0) -> DONE.
- x_vld low: history, fill and counters hold; no match possible.
- DONE: outputs hold; start -> RUN with counters cleared; cfg_we accepted.
- abort from any state -> IDLE next edge. match_cnt and config hold.
- Priority per cycle: abort > start > match > cfg_we.
- start in RUN ignored.
- cfg_we in RUN -> cfg_rej pulse, config unchanged.

## Timing
- All outputs registered. Reset values: z = 0, busy = 0, done = 0, timeout = 0, cfg_rej = 0, match_cnt = 0.
- Bit sampled at edge N completes a match -> z high for cycle N+1 only, match_cnt updated at N+1.
- Terminating match: z, done and match_cnt final value all visible at N+1; busy falls at N+1.
- start at edge N -> busy at N+1; first bit consumable at edge N+1.
- Earliest match is PAT_W valid bits after start. In overlap mode, matches may occur on consecutive valid bits if the pattern allows.
- rst_n assertion mid-RUN clears everything asynchronously; config returns to defaults.

## Configuration
- SEQDET_TIMEOUT_EN defined:
  - A TO_W-bit cycle counter runs in RUN. It clears on start and on every match, and counts every clk.
  - When it reaches all-ones: go to DONE with timeout = 1.
  - A match on the same edge wins, and timeout stays 0.
- Not defined: no counter logic; timeout tied to 0; RUN exits only on target or abort.

## Test plan
- Default config, start, stream 1,0,1,0 (x_vld = 1) -> z pulse one cycle after the 4th bit, match_cnt = 1, done = 1, busy = 0.
- Non-overlapping: pat 1010, ovl = 0, target = 0, stream 1010100 -> exactly one z. Same with ovl = 1 -> two z pulses, 2 valid bits apart, match_cnt = 2.
- x_vld gaps: 1,(gap 3 cycles),0,1,0 -> match detected; z delayed by the gaps only.
- cfg_we during RUN -> cfg_rej pulse, subsequent detection uses old pattern; abort and start in the same cycle -> IDLE.
- target = 3, pat 0110, ovl = 1, stream 0110110110 -> z at bits 4, 7 and 10; done after the 3rd; start from DONE clears match_cnt to 0.
- With SEQDET_TIMEOUT_EN, TO_W = 4, no matching data -> DONE with timeout = 1 on the 16th cycle after start. Without the macro -> remains busy.
